// File: rtl/mem_responder_if.sv
// Request/acknowledge signals between the cpu and mem_responder; the tristate
// data bus stays a plain inout port on the responder.
interface mem_responder_if;
    logic        readM;
    logic        writeM;
    logic [15:0] address;
    logic        ackOutput;
    logic        inputReady;

    modport master (
        output readM,
        output writeM,
        output address,
        input  ackOutput,
        input  inputReady
    );

    modport slave (
        input  readM,
        input  writeM,
        input  address,
        output ackOutput,
        output inputReady
    );
endinterface

// File: rtl/mem_responder.sv
// Single-port 16-bit word memory serving one cpu read/write at a fixed latency.
// Optional access counters are enabled with `define MEM_ACCESS_COUNT_EN.
module mem_responder #(
    parameter int unsigned LATENCY   = 4,
    parameter int unsigned ADDR_BITS = 8
) (
    input  logic            clk,
    input  logic            reset,
    mem_responder_if.slave  bus,
    inout  wire  [15:0]     data,
    output logic [15:0]     rd_count,
    output logic [15:0]     wr_count
);
    localparam int unsigned MEM_DEPTH = 2 ** ADDR_BITS;
    localparam logic [3:0]  WAIT_LOAD = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_DONE,
        WR_WAIT,
        WR_DONE
    } state_t;

    state_t                 state;
    logic [3:0]             cnt;
    logic [ADDR_BITS-1:0]   addr_q;
    logic [15:0]            wdata_q;
    logic [15:0]            rdata_q;
    logic                   ack_q;
    logic                   rdy_q;
    logic [15:0]            mem [MEM_DEPTH];

    logic [ADDR_BITS-1:0]   req_addr;
    logic                   can_accept;
    logic                   accept_rd;
    logic                   accept_wr;
    logic                   commit_wr;
    logic                   mem_we;
    logic [ADDR_BITS-1:0]   mem_waddr;
    logic [15:0]            mem_wdata;

    if (ADDR_BITS < 16) begin : g_addr_hi
        logic unused_addr_hi;
        assign unused_addr_hi = ^bus.address[15:ADDR_BITS];
    end

    // DONE states accept a new request so back-to-back transfers need no idle cycle.
    always_comb begin
        req_addr   = bus.address[ADDR_BITS-1:0];
        can_accept = (state == IDLE) || (state == RD_DONE) || (state == WR_DONE);
        accept_rd  = can_accept && bus.readM;
        accept_wr  = can_accept && !bus.readM && bus.writeM;
        commit_wr  = (state == WR_WAIT) && (cnt == 4'd0);
        mem_we     = !reset && (commit_wr || ((LATENCY == 1) && accept_wr));
        mem_waddr  = commit_wr ? addr_q  : req_addr;
        mem_wdata  = commit_wr ? wdata_q : data;
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ack_q   <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            rdy_q <= 1'b0;
            if (accept_rd) begin
                addr_q <= req_addr;
                if (LATENCY == 1) begin
                    rdata_q <= mem[req_addr];
                    ack_q   <= 1'b1;
                    state   <= RD_DONE;
                end else begin
                    cnt   <= WAIT_LOAD;
                    state <= RD_WAIT;
                end
            end else if (accept_wr) begin
                addr_q  <= req_addr;
                wdata_q <= data;
                if (LATENCY == 1) begin
                    rdy_q <= 1'b1;
                    state <= WR_DONE;
                end else begin
                    cnt   <= WAIT_LOAD;
                    state <= WR_WAIT;
                end
            end else begin
                case (state)
                    RD_WAIT: begin
                        if (!bus.readM) begin
                            state <= IDLE;
                        end else if (cnt == 4'd0) begin
                            rdata_q <= mem[addr_q];
                            ack_q   <= 1'b1;
                            state   <= RD_DONE;
                        end else begin
                            cnt <= cnt - 4'd1;
                        end
                    end
                    WR_WAIT: begin
                        if (cnt == 4'd0) begin
                            rdy_q <= 1'b1;
                            state <= WR_DONE;
                        end else begin
                            cnt <= cnt - 4'd1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.ackOutput  = ack_q;
    assign bus.inputReady = rdy_q;
    assign data = ((state == RD_DONE) && bus.readM) ? rdata_q : 'z;

`ifdef MEM_ACCESS_COUNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_count <= '0;
            wr_count <= '0;
        end else begin
            if (state == RD_DONE) begin
                rd_count <= rd_count + 16'd1;
            end
            if (state == WR_DONE) begin
                wr_count <= wr_count + 16'd1;
            end
        end
    end
`else
    assign rd_count = '0;
    assign wr_count = '0;
`endif
endmodule

// File: tb/tb_mem_responder.sv
// Randomized scoreboard bench for mem_responder (LATENCY=4) plus a directed LATENCY=1 instance.
module tb_mem_responder;
    localparam int unsigned LAT = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    wire  [15:0] data;
    wire  [15:0] data1;
    logic [15:0] rd_count, wr_count, rd_count1, wr_count1;
    logic        tb_drive  = 1'b0;
    logic        tb_drive1 = 1'b0;
    logic [15:0] tb_wdata  = '0;
    logic [15:0] tb_wdata1 = '0;

    mem_responder_if bus();
    mem_responder_if bus1();

    assign data  = tb_drive  ? tb_wdata  : 'z;
    assign data1 = tb_drive1 ? tb_wdata1 : 'z;

    mem_responder #(.LATENCY(LAT), .ADDR_BITS(8)) dut (
        .clk(clk), .reset(reset), .bus(bus), .data(data),
        .rd_count(rd_count), .wr_count(wr_count)
    );

    mem_responder #(.LATENCY(1), .ADDR_BITS(8)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1), .data(data1),
        .rd_count(rd_count1), .wr_count(wr_count1)
    );

    typedef struct {
        bit          is_rd;
        logic [15:0] val;
        int unsigned due;
    } exp_t;

    exp_t        sbq[$];
    logic [15:0] model [256];
    int unsigned cyc = 0;
    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned exp_rd = 0;
    int unsigned exp_wr = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h cycle=%0d", name, act, req, cyc);
        end
    endtask

    // Monitor: every pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            if (cyc > 0) begin
                check("reset_ack", 32'(bus.ackOutput), 32'd0);
                check("reset_rdy", 32'(bus.inputReady), 32'd0);
            end
        end else begin
            if (bus.ackOutput || bus.inputReady)
                check("ack_rdy_exclusive", 32'(bus.ackOutput & bus.inputReady), 32'd0);
            if (bus.ackOutput) begin
                if (sbq.size() == 0 || !sbq[0].is_rd) begin
                    checks++; errors++;
                    $display("FAIL unexpected_ack actual=1 required=0 cycle=%0d", cyc);
                end else begin
                    e = sbq.pop_front();
                    check("rd_cycle", cyc, e.due);
                    check("rd_data", 32'(data), 32'(e.val));
                end
            end
            if (bus.inputReady) begin
                if (sbq.size() == 0 || sbq[0].is_rd) begin
                    checks++; errors++;
                    $display("FAIL unexpected_ready actual=1 required=0 cycle=%0d", cyc);
                end else begin
                    e = sbq.pop_front();
                    check("wr_cycle", cyc, e.due);
                end
            end
            if (sbq.size() > 0 && cyc > sbq[0].due) begin
                checks++; errors++;
                $display("FAIL timeout actual=none required=pulse_at_%0d cycle=%0d", sbq[0].due, cyc);
                void'(sbq.pop_front());
            end
        end
    end

    task automatic idle_inputs();
        bus.readM  = 1'b0;
        bus.writeM = 1'b0;
        tb_drive   = 1'b0;
    endtask

    // All tasks start and end at negedge+2, so a request can be taken on the next edge.
    task automatic do_write(input logic [15:0] addr, input logic [15:0] val,
                            input bit drop_early, input bit reset_mid);
        int unsigned acc;
        bus.readM   = 1'b0;
        bus.writeM  = 1'b1;
        bus.address = addr;
        tb_wdata    = val;
        tb_drive    = 1'b1;
        @(negedge clk);
        acc = cyc;
        #2;
        if (reset_mid) begin
            reset = 1'b1;
            repeat (2) @(negedge clk);
            #2;
            reset = 1'b0;
            exp_rd = 0;
            exp_wr = 0;
            idle_inputs();
            return;
        end
        model[addr[7:0]] = val;
        exp_wr++;
        sbq.push_back('{is_rd: 1'b0, val: val, due: acc + LAT - 1});
        if (drop_early) begin
            bus.writeM = 1'b0;
            tb_drive   = 1'b0;
        end
        repeat (LAT - 1) @(negedge clk);
        #2;
        idle_inputs();
    endtask

    task automatic do_read(input logic [15:0] addr, input bit both, input bit abort);
        int unsigned acc;
        bus.readM   = 1'b1;
        bus.writeM  = both;
        bus.address = addr;
        tb_wdata    = 16'($urandom);
        tb_drive    = 1'b0;
        @(negedge clk);
        acc = cyc;
        #2;
        bus.writeM = 1'b0;
        if (abort) begin
            @(negedge clk);
            #2;
            bus.readM = 1'b0;
            @(negedge clk);
            #2;
            return;
        end
        exp_rd++;
        sbq.push_back('{is_rd: 1'b1, val: model[addr[7:0]], due: acc + LAT - 1});
        repeat (LAT - 1) @(negedge clk);
        #2;
        idle_inputs();
    endtask

    initial begin
        logic [15:0] a;
        int unsigned op;

        reset         = 1'b1;
        idle_inputs();
        bus.readM     = 1'b1;
        bus.address   = '0;
        bus1.readM    = 1'b0;
        bus1.writeM   = 1'b0;
        bus1.address  = '0;
        repeat (2) @(negedge clk);
        #2;
        reset = 1'b0;
        idle_inputs();

        check("rst_rd_count", 32'(rd_count), 32'd0);
        check("rst_wr_count", 32'(wr_count), 32'd0);

        // LATENCY=1: aliased write then back-to-back read, each pulse one cycle after acceptance.
        bus1.writeM  = 1'b1;
        bus1.address = 16'h0105;
        tb_wdata1    = 16'h1234;
        tb_drive1    = 1'b1;
        @(negedge clk);
        check("l1_wr_ready", 32'(bus1.inputReady), 32'd1);
        #2;
        bus1.writeM  = 1'b0;
        tb_drive1    = 1'b0;
        bus1.readM   = 1'b1;
        bus1.address = 16'h0005;
        @(negedge clk);
        check("l1_rd_ack", 32'(bus1.ackOutput), 32'd1);
        check("l1_rd_data", 32'(data1), 32'h1234);
        check("l1_no_ready", 32'(bus1.inputReady), 32'd0);
        #2;
        bus1.readM = 1'b0;
        @(negedge clk);
        check("l1_ack_one_cycle", 32'(bus1.ackOutput), 32'd0);
        #2;

        for (int i = 0; i < 64; i++) do_write(16'(i), 16'($urandom), 1'b0, 1'b0);

        do_write(16'h0012, 16'hBEEF, 1'b0, 1'b0);
        do_read(16'h0012, 1'b0, 1'b0);
        do_read(16'h0003, 1'b1, 1'b0);
        do_read(16'h0003, 1'b0, 1'b0);
        do_read(16'h0010, 1'b0, 1'b1);
        do_write(16'h0105, 16'h1234, 1'b0, 1'b0);
        do_read(16'h0005, 1'b0, 1'b0);
        do_write(16'h0020, 16'hAAAA, 1'b0, 1'b1);
        do_read(16'h0020, 1'b0, 1'b0);

        for (int n = 0; n < 150; n++) begin
            op = $urandom_range(0, 9);
            a  = {8'($urandom), 2'b00, 6'($urandom)};
            if (op <= 3)      do_write(a, 16'($urandom), 1'($urandom), 1'b0);
            else if (op <= 6) do_read(a, 1'b0, 1'b0);
            else if (op == 7) do_read(a, 1'b1, 1'b0);
            else if (op == 8) do_read(a, 1'b0, 1'b1);
            else begin
                repeat ($urandom_range(1, 3)) @(negedge clk);
                #2;
            end
        end

        repeat (LAT + 4) @(negedge clk);
        check("scoreboard_drained", sbq.size(), 32'd0);
`ifdef MEM_ACCESS_COUNT_EN
        check("rd_count", 32'(rd_count), 32'(16'(exp_rd)));
        check("wr_count", 32'(wr_count), 32'(16'(exp_wr)));
`else
        check("rd_count_tied", 32'(rd_count), 32'd0);
        check("wr_count_tied", 32'(wr_count), 32'd0);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
